// File: rtl/mmio_port_pkg.sv
// Shared constants for the MMIO port responder: register offsets, bit indices, reset values.
package mmio_port_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned ST_W   = 2;
    localparam int unsigned CT_W   = 4;

    localparam logic [OFF_W-1:0] OFF_PORT_OUT  = 3'd0;
    localparam logic [OFF_W-1:0] OFF_PORT_IN   = 3'd1;
    localparam logic [OFF_W-1:0] OFF_STATUS    = 3'd2;
    localparam logic [OFF_W-1:0] OFF_TMR_COUNT = 3'd3;
    localparam logic [OFF_W-1:0] OFF_TMR_CMP   = 3'd4;
    localparam logic [OFF_W-1:0] OFF_CONTROL   = 3'd5;

    localparam int unsigned ST_IN_CHG    = 0;
    localparam int unsigned ST_TMR_MATCH = 1;

    localparam int unsigned CT_TMR_EN      = 0;
    localparam int unsigned CT_AUTO_RELOAD = 1;
    localparam int unsigned CT_IE_CHG      = 2;
    localparam int unsigned CT_IE_MATCH    = 3;

    localparam logic [DATA_W-1:0] TMR_CMP_RESET = 32'hFFFF_FFFF;

    // Interrupt level from a status/control pair.
    function automatic logic irq_level(input logic [ST_W-1:0] st, input logic [CT_W-1:0] ct);
        return (st[ST_IN_CHG] & ct[CT_IE_CHG]) | (st[ST_TMR_MATCH] & ct[CT_IE_MATCH]);
    endfunction

endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-memory load/store bus as seen by a memory-mapped target.
interface mmio_port_responder_if;
    import mmio_port_pkg::*;

    logic [DATA_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] ReadData;
    logic              Hit;

    modport master (output Address, WriteData, MemWrite, MemRead, input ReadData, Hit);
    modport slave  (input Address, WriteData, MemWrite, MemRead, output ReadData, Hit);

endinterface

// File: rtl/input_sync_edge.sv
// Two-flop synchronizer for asynchronous inputs plus a history stage for change detection.
module input_sync_edge #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             chg_c
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign sync_o = sync2_q;
    assign chg_c  = (sync2_q != prev_q);

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO target beside the data RAM: output port, synchronized input port and compare timer with IRQ.
module mmio_port_responder
    import mmio_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS  = 32'h1001_0000,
    parameter int unsigned PORT_IN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    mmio_port_responder_if.slave     bus,
    input  logic [PORT_IN_WIDTH-1:0] PortIn,
    output logic [DATA_W-1:0]        PortOut,
    output logic                     Irq
);

    logic                     hit_c;
    logic [OFF_W-1:0]         off_c;
    logic                     wr_en_c;
    logic                     rd_en_c;
    logic                     unused_addr_lo;

    logic [PORT_IN_WIDTH-1:0] port_in_sync;
    logic                     in_chg_c;
    logic                     tmr_match_c;

    logic [DATA_W-1:0] port_out_q, port_out_d;
    logic [ST_W-1:0]   status_q,   status_d;
    logic [DATA_W-1:0] count_q,    count_d;
    logic [DATA_W-1:0] cmp_q,      cmp_d;
    logic [CT_W-1:0]   ctrl_q,     ctrl_d;
    logic              irq_q,      irq_d;
    logic [DATA_W-1:0] rdata_c;

    // Word-granular decode of a 32-byte window; byte lanes are ignored.
    assign hit_c          = (bus.Address[31:5] == BASE_ADDRESS[31:5]);
    assign off_c          = bus.Address[4:2];
    assign wr_en_c        = hit_c & bus.MemWrite;
    assign rd_en_c        = hit_c & bus.MemRead;
    assign unused_addr_lo = ^bus.Address[1:0];

    input_sync_edge #(
        .WIDTH (PORT_IN_WIDTH)
    ) u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .d_i    (PortIn),
        .sync_o (port_in_sync),
        .chg_c  (in_chg_c)
    );

    assign tmr_match_c = ctrl_q[CT_TMR_EN] & (count_q == cmp_q);

    // Next-state: bus writes override the timer; hardware status sets override W1C clears.
    always_comb begin
        port_out_d = port_out_q;
        status_d   = status_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        ctrl_d     = ctrl_q;

        if (ctrl_q[CT_TMR_EN]) begin
            count_d = (tmr_match_c && ctrl_q[CT_AUTO_RELOAD]) ? '0 : count_q + 32'd1;
        end

        if (wr_en_c) begin
            case (off_c)
                OFF_PORT_OUT:  port_out_d = bus.WriteData;
                OFF_STATUS:    status_d   = status_q & ~bus.WriteData[ST_W-1:0];
                OFF_TMR_COUNT: count_d    = bus.WriteData;
                OFF_TMR_CMP:   cmp_d      = bus.WriteData;
                OFF_CONTROL:   ctrl_d     = bus.WriteData[CT_W-1:0];
                default:       ;
            endcase
        end

        if (in_chg_c)    status_d[ST_IN_CHG]    = 1'b1;
        if (tmr_match_c) status_d[ST_TMR_MATCH] = 1'b1;

        irq_d = irq_level(status_d, ctrl_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q <= '0;
            status_q   <= '0;
            count_q    <= '0;
            cmp_q      <= TMR_CMP_RESET;
            ctrl_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            status_q   <= status_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
        end
    end

    // Zero-wait-state read mux from current (pre-write) register state.
    always_comb begin
        rdata_c = '0;
        if (rd_en_c) begin
            case (off_c)
                OFF_PORT_OUT:  rdata_c = port_out_q;
                OFF_PORT_IN:   rdata_c = DATA_W'(port_in_sync);
                OFF_STATUS:    rdata_c = DATA_W'(status_q);
                OFF_TMR_COUNT: rdata_c = count_q;
                OFF_TMR_CMP:   rdata_c = cmp_q;
                OFF_CONTROL:   rdata_c = DATA_W'(ctrl_q);
                default:       rdata_c = '0;
            endcase
        end
    end

    assign bus.ReadData = rdata_c;
    assign bus.Hit      = hit_c;
    assign PortOut      = port_out_q;
    assign Irq          = irq_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Randomized bench for mmio_port_responder against a register-map model, plus pinned directed checks.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE        = 32'h1001_0000;
    localparam logic [31:0] A_PORT_OUT  = BASE + 32'h00;
    localparam logic [31:0] A_PORT_IN   = BASE + 32'h04;
    localparam logic [31:0] A_STATUS    = BASE + 32'h08;
    localparam logic [31:0] A_TMR_COUNT = BASE + 32'h0C;
    localparam logic [31:0] A_TMR_CMP   = BASE + 32'h10;
    localparam logic [31:0] A_CONTROL   = BASE + 32'h14;

    localparam int L_NONE = 0;
    localparam int L_RD   = 1;
    localparam int L_PO   = 2;
    localparam int L_IRQ  = 3;
    localparam int L_HIT  = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  port_in;
    logic [31:0] port_out;
    logic        irq;

    mmio_port_responder_if bus();

    mmio_port_responder #(
        .BASE_ADDRESS  (BASE),
        .PORT_IN_WIDTH (8)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .bus     (bus),
        .PortIn  (port_in),
        .PortOut (port_out),
        .Irq     (irq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_on = 1'b0;
    int          lit_sel = L_NONE;
    logic [31:0] lit_exp = '0;
    string       lit_nm = "";

    // Register-map model.
    logic [31:0] m_port_out, m_count, m_cmp;
    logic [1:0]  m_status;
    logic [3:0]  m_ctrl;
    logic        m_irq;
    logic [7:0]  m_pin [3];   // PortIn samples at the last three edges, newest first
    bit          m_wr, m_chg, m_match;
    logic [2:0]  m_off;
    logic [1:0]  m_clr;
    logic [31:0] m_wd;

    function automatic bit in_window(input logic [31:0] a);
        longint unsigned x, b;
        x = longint'(a);
        b = longint'(BASE);
        return (x >= b) && (x < b + 64'd32);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] o);
        case (o)
            3'd0:    return m_port_out;
            3'd1:    return {24'd0, m_pin[1]};
            3'd2:    return {30'd0, m_status};
            3'd3:    return m_count;
            3'd4:    return m_cmp;
            3'd5:    return {28'd0, m_ctrl};
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_port_out = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF;
            m_status = '0; m_ctrl = '0; m_irq = 1'b0;
            for (int k = 0; k < 3; k++) m_pin[k] = 8'h00;
        end else begin
            m_wr    = in_window(bus.Address) && bus.MemWrite;
            m_off   = bus.Address[4:2];
            m_wd    = bus.WriteData;
            m_chg   = (m_pin[1] != m_pin[2]);
            m_match = m_ctrl[0] && (m_count == m_cmp);
            if (m_wr && m_off == 3'd3)      m_count = m_wd;
            else if (m_ctrl[0])             m_count = (m_match && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
            m_clr    = (m_wr && m_off == 3'd2) ? m_wd[1:0] : 2'b00;
            m_status = (m_status & ~m_clr) | {m_match, m_chg};
            if (m_wr && m_off == 3'd0) m_port_out = m_wd;
            if (m_wr && m_off == 3'd4) m_cmp = m_wd;
            if (m_wr && m_off == 3'd5) m_ctrl = m_wd[3:0];
            m_irq = (m_status[0] & m_ctrl[2]) | (m_status[1] & m_ctrl[3]);
            m_pin[2] = m_pin[1];
            m_pin[1] = m_pin[0];
            m_pin[0] = port_in;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic        e_hit;
    logic [31:0] e_rd;

    // Single compare process: model checks every cycle, plus any pinned literal.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            e_hit = in_window(bus.Address);
            e_rd  = (e_hit && bus.MemRead) ? m_read(bus.Address[4:2]) : 32'd0;
            cmp("Hit", 32'(bus.Hit), 32'(e_hit));
            cmp("ReadData", bus.ReadData, e_rd);
            cmp("PortOut", port_out, m_port_out);
            cmp("Irq", 32'(irq), 32'(m_irq));
            case (lit_sel)
                L_RD:    cmp({"lit ", lit_nm}, bus.ReadData, lit_exp);
                L_PO:    cmp({"lit ", lit_nm}, port_out, lit_exp);
                L_IRQ:   cmp({"lit ", lit_nm}, 32'(irq), lit_exp);
                L_HIT:   cmp({"lit ", lit_nm}, 32'(bus.Hit), lit_exp);
                default: ;
            endcase
        end
    end

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit re,
                        input int sel, input logic [31:0] ex, input string nm);
        @(posedge clk);
        #1;
        bus.Address   = a;
        bus.WriteData = wd;
        bus.MemWrite  = we;
        bus.MemRead   = re;
        lit_sel       = sel;
        lit_exp       = ex;
        lit_nm        = nm;
    endtask

    logic [31:0] r_a, r_wd;
    logic [2:0]  r_o;

    initial begin
        bus.Address = '0; bus.WriteData = '0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
        port_in = 8'h00;
        repeat (2) @(posedge clk);
        chk_on = 1'b1;

        step(A_TMR_CMP, 0, 0, 1, L_RD,  32'hFFFF_FFFF, "reset TMR_CMP");
        step(A_CONTROL, 0, 0, 1, L_RD,  32'h0,         "reset CONTROL");
        step(A_STATUS,  0, 0, 1, L_IRQ, 32'h0,         "reset Irq");
        step(A_TMR_CMP, 0, 0, 0, L_RD,  32'h0,         "reset ReadData idle");
        rst_n = 1'b1;

        step(A_PORT_OUT, 32'hA5A5_0F0F, 1, 0, L_PO, 32'h0, "PortOut before write");
        step(A_PORT_OUT, 0, 0, 1, L_PO,  32'hA5A5_0F0F, "PortOut after write");
        step(A_PORT_OUT, 0, 0, 1, L_RD,  32'hA5A5_0F0F, "read PORT_OUT");
        step(BASE + 32'h1F, 0, 0, 1, L_HIT, 32'h1, "Hit top of window");
        step(BASE + 32'h20, 0, 0, 1, L_HIT, 32'h0, "Hit above window");
        step(BASE - 32'h4,  0, 0, 1, L_HIT, 32'h0, "Hit below window");
        step(BASE,          0, 0, 0, L_HIT, 32'h1, "Hit base");

        step(A_CONTROL, 32'h4, 1, 0, L_NONE, 0, "");
        step(A_PORT_IN, 0, 0, 1, L_RD, 32'h00, "PORT_IN before change");
        port_in = 8'h3C;
        step(A_PORT_IN, 0, 0, 1, L_RD,  32'h00, "PORT_IN after 1 edge");
        step(A_PORT_IN, 0, 0, 1, L_RD,  32'h3C, "PORT_IN after 2 edges");
        step(A_STATUS,  0, 0, 1, L_RD,  32'h1,  "IN_CHG at 3rd edge");
        step(A_STATUS,  0, 0, 1, L_IRQ, 32'h1,  "Irq on IN_CHG");
        step(A_STATUS,  1, 1, 0, L_NONE, 0, "");
        step(A_STATUS,  0, 0, 1, L_IRQ, 32'h0,  "Irq after W1C");
        step(A_STATUS,  0, 0, 1, L_RD,  32'h0,  "STATUS after W1C");

        step(A_TMR_CMP, 32'd5, 1, 0, L_NONE, 0, "");
        step(A_CONTROL, 32'h3, 1, 0, L_NONE, 0, "");
        for (int k = 0; k < 5; k++) step(A_TMR_COUNT, 0, 0, 1, L_RD, 32'(k), "timer count");
        step(A_STATUS,    2, 1, 1, L_RD, 32'h0, "STATUS pre-write on match edge");
        step(A_STATUS,    0, 0, 1, L_RD, 32'h2, "match beats W1C");
        step(A_TMR_COUNT, 0, 0, 1, L_RD, 32'h1, "auto-reload recount");
        step(A_TMR_COUNT, 32'd100, 1, 0, L_NONE, 0, "");
        step(A_TMR_COUNT, 0, 0, 1, L_RD, 32'd100, "count write beats increment");

        step(A_TMR_COUNT, 32'd1, 1, 0, L_NONE, 0, "");
        step(A_PORT_OUT,  0, 0, 1, L_RD, 32'hA5A5_0F0F, "PortOut before reset");
        step(A_TMR_COUNT, 0, 0, 1, L_RD, 32'd2, "count 2");
        step(A_TMR_COUNT, 0, 0, 1, L_RD, 32'd3, "count 3");
        step(A_TMR_CMP,   0, 0, 1, L_RD, 32'hFFFF_FFFF, "TMR_CMP after async reset");
        #2 rst_n = 1'b0;
        step(A_TMR_COUNT, 0, 0, 1, L_PO, 32'h0, "PortOut in reset");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(A_TMR_COUNT, 0, 0, 1, L_RD, 32'h0, "count frozen after reset");
        step(A_CONTROL,   32'h1, 1, 0, L_NONE, 0, "");
        step(A_TMR_COUNT, 0, 0, 1, L_RD, 32'h0, "no increment on enable edge");
        step(A_TMR_COUNT, 0, 0, 1, L_RD, 32'h1, "count runs after enable");

        step(BASE + 32'h18, 0, 0, 1, L_RD, 32'h0, "reserved 0x18 reads 0");
        step(BASE + 32'h1C, 32'hFFFF_FFFF, 1, 0, L_NONE, 0, "");
        step(A_PORT_OUT, 0, 0, 1, L_RD, 32'h0, "0x1C write ignored");
        step(32'h1000_FFFC, 32'hDEAD_BEEF, 1, 1, L_RD, 32'h0, "outside ReadData");
        step(BASE + 32'h20, 32'hDEAD_BEEF, 1, 0, L_HIT, 32'h0, "outside alias Hit");
        step(A_PORT_OUT, 0, 0, 1, L_RD, 32'h0, "outside store ignored");

        for (int i = 0; i < 3000; i++) begin
            r_o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       r_a = BASE + 32'h20 + 32'($urandom_range(0, 255));
                1:       r_a = BASE - 32'($urandom_range(1, 64));
                default: r_a = BASE + 32'({r_o, 2'($urandom_range(0, 3))});
            endcase
            case (r_o)
                3'd3:    r_wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 12));
                3'd4:    r_wd = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
                default: r_wd = 32'($urandom);
            endcase
            step(r_a, r_wd, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, L_NONE, 0, "");
            if ($urandom_range(0, 7) == 0) port_in = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        step(32'h0, 0, 0, 0, L_NONE, 0, "");
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder: the target side of the processor's data-memory load/store interface.
- Decodes a small address window and answers loads and stores.
- Owns the output port register, a synchronized input port with change detection, and a compare timer with a level interrupt.
- Sits beside the data RAM. The processor's read-data mux selects this block's ReadData whenever Hit=1.

Parameters:
- BASE_ADDRESS, 32'h1001_0000: window base; must be 32-byte aligned.
- PORT_IN_WIDTH, 8: width of PortIn.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Address  input  32  byte address from the ALU result
- WriteData  input  32  store data (rt)
- MemWrite  input  1  store strobe, one cycle per store
- MemRead  input  1  load strobe
- PortIn  input  PORT_IN_WIDTH  external asynchronous inputs
- ReadData  output  32  load data (combinational)
- Hit  output  1  Address is inside the window
- PortOut  output  32  output port register
- Irq  output  1  level interrupt

Behaviour:
- Decode: Hit = (Address[31:5] == BASE_ADDRESS[31:5]). Offset = Address[4:2]. Address[1:0] is ignored; only word access is supported.
- Register map (offset: name, access):
  - 0x00 PORT_OUT, RW.
  - 0x04 PORT_IN, RO. Zero-extended synchronized input.
  - 0x08 STATUS, W1C. bit0 IN_CHG, bit1 TMR_MATCH.
  - 0x0C TMR_COUNT, RW.
  - 0x10 TMR_CMP, RW.
  - 0x14 CONTROL, RW. bit0 TMR_EN, bit1 AUTO_RELOAD, bit2 IE_CHG, bit3 IE_MATCH. Bits 31:4 read 0.
  - 0x18, 0x1C reserved. Reads return 0; writes are ignored.
- Reads:
  - ReadData is combinational from current register state when Hit & MemRead; otherwise 0.
  - Zero wait states, to match the single-cycle datapath.
- Writes: take effect at the rising clk edge where Hit & MemWrite.
- MemRead and MemWrite together: the write is performed, and ReadData shows the pre-write value.
- Reset (reset=0, asynchronous):
  - PortOut=0, synchronizer stages=0, STATUS=0, TMR_COUNT=0, TMR_CMP=32'hFFFF_FFFF, CONTROL=0.
  - Irq=0 and ReadData=0 (with MemRead=0).
  - Reset release resumes cleanly from these values; any in-flight store is discarded.
- Input path:
  - sync1<=PortIn, sync2<=sync1, prev<=sync2.
  - PORT_IN reads sync2, so a PortIn change is visible after 2 edges.
  - IN_CHG is set at any edge where sync2 != prev, i.e. the 3rd edge after the change.
- Timer:
  - When TMR_EN=1, TMR_COUNT increments by 1 each edge, wrapping 32'hFFFF_FFFF -> 0.
  - At an edge where TMR_EN=1 and TMR_COUNT==TMR_CMP, TMR_MATCH is set.
  - If AUTO_RELOAD=1, TMR_COUNT loads 0 at that edge; otherwise it continues incrementing.
  - TMR_EN=0 freezes the count.
- Simultaneous events:
  - A TMR_COUNT write in the same cycle as an increment or reload: the write wins.
  - A W1C clear in the same cycle as a hardware set of the same bit: the set wins, and the bit stays 1.
  - A CONTROL write enabling the timer takes effect the following edge; no increment occurs on the write edge.
  - A TMR_CMP write lands on the edge; the comparison on that edge uses the old TMR_CMP.
- Irq: registered. Irq <= (IN_CHG & IE_CHG) | (TMR_MATCH & IE_MATCH), computed from next-state values, so Irq tracks STATUS on the same edge.
- No Hit: ReadData=0, no state change; the block is fully transparent.

Decomposition:
- Package mmio_port_pkg holds:
  - offset constants OFF_PORT_OUT..OFF_CONTROL;
  - STATUS bit indices ST_IN_CHG, ST_TMR_MATCH;
  - CONTROL bit indices CT_TMR_EN, CT_AUTO_RELOAD, CT_IE_CHG, CT_IE_MATCH;
  - reset constant TMR_CMP_RESET.
- One sub-module, input_sync_edge:
  - 2-flop synchronizer plus prev-stage register;
  - parameterized by width;
  - outputs a synchronized value and a one-cycle change pulse.
- Address decode, register file, timer and read mux stay in the top.

Test Plan:
- Reset, then write 0x00 = 32'hA5A5_0F0F -> PortOut = 32'hA5A5_0F0F on the next edge; read 0x00 returns the same value; Hit=1 only within 0x1001_0000-0x1001_001F.
- PortIn 8'h00 -> 8'h3C:
  - PORT_IN reads 0x3C after 2 edges;
  - STATUS bit0 = 1 at the 3rd edge;
  - with IE_CHG=1, Irq=1 on the same edge;
  - write STATUS = 1 -> bit0 = 0 and Irq = 0 next edge.
- TMR_CMP = 5, CONTROL = 32'h3 -> count runs 0..5, then 0; TMR_MATCH sets at the edge where count==5; subsequent reads show wrap to 0 and recount.
- Simultaneous: W1C of TMR_MATCH on the exact match edge -> bit remains 1. TMR_COUNT write of 100 while enabled -> next read 100, not 101.
- Assert reset mid-count (count=3, PortOut nonzero) -> all registers return to reset values immediately, asynchronously; read 0x10 = 32'hFFFF_FFFF; timer stays frozen after release until TMR_EN is set.
- Read 0x18 -> 0; write 0x1C -> no register changes. Address 0x1000_FFFC -> Hit=0, ReadData=0, store ignored.
